// File: rtl/seq_match_monitor_pkg.sv
// Shared types and constants for the match-rate monitor.
package seq_match_monitor_pkg;

  typedef logic [0:0] state_t;
  localparam state_t QUIET = 1'b0;
  localparam state_t ALERT = 1'b1;

  // Wide all-ones sentinel; users slice it to their gap width.
  localparam logic [31:0] GAP_NONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/seq_match_monitor_if.sv
// Report channel of the match-rate monitor: valid/ready report plus sticky loss flag.
// rpt_min_gap and GAP_W exist only when SEQ_MATCH_MONITOR_GAP_EN is defined.
interface seq_match_monitor_if #(
  parameter int CNT_W = 8
`ifdef SEQ_MATCH_MONITOR_GAP_EN
  , parameter int GAP_W = 7
`endif
);

  logic [CNT_W-1:0] rpt_data;
  logic             rpt_valid;
  logic             rpt_ready;
  logic             rpt_lost;
`ifdef SEQ_MATCH_MONITOR_GAP_EN
  logic [GAP_W-1:0] rpt_min_gap;

  modport master (output rpt_data, output rpt_valid, output rpt_lost,
                  output rpt_min_gap, input rpt_ready);
  modport slave  (input rpt_data, input rpt_valid, input rpt_lost,
                  input rpt_min_gap, output rpt_ready);
`else
  modport master (output rpt_data, output rpt_valid, output rpt_lost,
                  input rpt_ready);
  modport slave  (input rpt_data, input rpt_valid, input rpt_lost,
                  output rpt_ready);
`endif

endinterface

// File: rtl/seq_match_window_timer.sv
// Enable-gated window counter; flags the last enabled cycle of each window.
module seq_match_window_timer #(
  parameter int WINDOW = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clr,
  output logic wend
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] LAST = WIN_W'(WINDOW - 1);

  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;

  assign wend = enable && (win_cnt_q == LAST);

  always_comb begin
    win_cnt_d = win_cnt_q;
    if (clr)         win_cnt_d = '0;
    else if (wend)   win_cnt_d = '0;
    else if (enable) win_cnt_d = win_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) win_cnt_q <= '0;
    else       win_cnt_q <= win_cnt_d;
  end

endmodule

// File: rtl/seq_match_monitor.sv
// Counts detector matches per window, reports each window count over valid/ready
// and tracks a match-rate alert. Optional SEQ_MATCH_MONITOR_GAP_EN adds min-gap reporting.
module seq_match_monitor
  import seq_match_monitor_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int WINDOW   = 64,
  parameter int ALERT_TH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic z,
  input  logic enable,
  input  logic clr,
  output logic alert,
  seq_match_monitor_if.master rpt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TH      = CNT_W'(ALERT_TH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != CNT_MAX)) return v + 1'b1;
    return v;
  endfunction

  logic             wend;
  logic             zen;
  logic [CNT_W-1:0] m_cnt_q, m_cnt_d, snap;
  logic [CNT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             lost_q, lost_d;
  state_t           state_q, state_d;

  seq_match_window_timer #(.WINDOW(WINDOW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clr    (clr),
    .wend   (wend)
  );

  assign zen  = z & enable;
  assign snap = sat_inc(m_cnt_q, zen);

  always_comb begin
    m_cnt_d = snap;
    if (clr || wend) m_cnt_d = '0;
  end

  // Report slot: a window end always loads; an unaccepted pending report counts as lost.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    lost_d  = lost_q;
    if (clr) begin
      data_d  = '0;
      valid_d = 1'b0;
      lost_d  = 1'b0;
    end else if (wend) begin
      data_d  = snap;
      valid_d = 1'b1;
      if (valid_q && !rpt.rpt_ready) lost_d = 1'b1;
    end else if (valid_q && rpt.rpt_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = QUIET;
    end else begin
      case (state_q)
        QUIET:   if (zen && (snap >= TH)) state_d = ALERT;
        ALERT:   if (wend && (snap < TH)) state_d = QUIET;
        default: state_d = QUIET;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      lost_q  <= 1'b0;
      state_q <= QUIET;
    end else begin
      m_cnt_q <= m_cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      lost_q  <= lost_d;
      state_q <= state_d;
    end
  end

  assign alert         = (state_q == ALERT);
  assign rpt.rpt_data  = data_q;
  assign rpt.rpt_valid = valid_q;
  assign rpt.rpt_lost  = lost_q;

`ifdef SEQ_MATCH_MONITOR_GAP_EN
  localparam int GAP_W = $clog2(WINDOW) + 1;
  localparam logic [GAP_W-1:0] GAP_ONES = GAP_NONE[GAP_W-1:0];

  logic             seen_q, seen_d;
  logic [GAP_W-1:0] dist_q, dist_d;
  logic [GAP_W-1:0] min_q, min_d, cur_min;
  logic [GAP_W-1:0] gap_q, gap_d;

  // dist_q holds enabled cycles since the last match, so it is the gap when z arrives.
  always_comb begin
    cur_min = min_q;
    if (zen && seen_q && (dist_q < min_q)) cur_min = dist_q;
    seen_d = seen_q;
    dist_d = dist_q;
    min_d  = min_q;
    gap_d  = gap_q;
    if (clr) begin
      seen_d = 1'b0;
      dist_d = '0;
      min_d  = GAP_ONES;
      gap_d  = GAP_ONES;
    end else if (wend) begin
      seen_d = 1'b0;
      dist_d = '0;
      min_d  = GAP_ONES;
      gap_d  = cur_min;
    end else if (enable) begin
      min_d = cur_min;
      if (z) begin
        seen_d = 1'b1;
        dist_d = GAP_W'(1);
      end else begin
        dist_d = dist_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen_q <= 1'b0;
      dist_q <= '0;
      min_q  <= GAP_ONES;
      gap_q  <= GAP_ONES;
    end else begin
      seen_q <= seen_d;
      dist_q <= dist_d;
      min_q  <= min_d;
      gap_q  <= gap_d;
    end
  end

  assign rpt.rpt_min_gap = gap_q;
`endif

endmodule

// File: doc/seq_match_monitor.md
Name: seq_match_monitor

Overview:
- Downstream consumer of the sequence detector's one-cycle match pulse `z`.
- Divides time into fixed windows of WINDOW enabled cycles and counts matches in each window.
- At the end of every window it publishes the count as a report over a valid/ready handshake.
- Raises a registered `alert` while matches per window are at or above a threshold.

Parameters:
- CNT_W, 8, width of the match counter and of the report data.
- WINDOW, 64, window length in enabled cycles (>=2).
- ALERT_TH, 4, match count per window that triggers the alert (1..2^CNT_W-1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- z  in  1  match pulse from the detector; one pulse per match.
- enable  in  1  when 0, the window timer, counters and FSM hold, and `z` is ignored.
- clr  in  1  synchronous clear of all state; same effect as reset; highest priority.
- rpt_data  out  CNT_W  match count of the last completed window.
- rpt_valid  out  1  `rpt_data` is valid.
- rpt_ready  in  1  consumer accepts the report.
- rpt_lost  out  1  sticky: an unaccepted report was overwritten.
- alert  out  1  alert state indicator.

Behaviour:
- Reset/clr values: `rpt_data`=0, `rpt_valid`=0, `rpt_lost`=0, `alert`=0, window counter=0, match counter=0, FSM=QUIET.
- Window counter `win_cnt` runs 0..WINDOW-1 and advances only when `enable`=1. The window-end cycle (`wend`) is `win_cnt`==WINDOW-1 with `enable`=1; `win_cnt` wraps to 0 after it.
- Match counter `m_cnt` increments on `z` & `enable` and saturates at 2^CNT_W-1 (no wrap).
- On `wend` the snapshot value is `m_cnt` plus the `z` of that same cycle, saturated.
  - Snapshot goes to `rpt_data` and `rpt_valid` rises on the next cycle (latency 1).
  - `m_cnt` restarts at 0 for the new window.
- Handshake:
  - A transfer occurs when `rpt_valid`=1 and `rpt_ready`=1; `rpt_valid` drops next cycle unless a new snapshot loads that same cycle.
  - `rpt_data` is stable while `rpt_valid`=1 and `rpt_ready`=0, except on an overwrite.
- Overwrite: `wend` with `rpt_valid`=1 and `rpt_ready`=0 loads the new snapshot, keeps `rpt_valid`=1, and sets `rpt_lost`.
  - If `rpt_ready`=1 in that same cycle, the old report transfers, the new one loads, and `rpt_lost` is unchanged.
- `rpt_lost` clears only on reset or `clr`.
- FSM (states QUIET, ALERT; `alert` = state==ALERT, registered):
  - QUIET -> ALERT in the cycle after the enabled `z` that makes the current-window count reach ALERT_TH.
  - ALERT -> QUIET after a `wend` whose snapshot < ALERT_TH.
  - ALERT stays while each completed window snapshot >= ALERT_TH.
  - Within a window ALERT never drops early.
- `enable`=0 mid-window freezes `win_cnt`, `m_cnt` and FSM; the handshake keeps operating.
- Asynchronous reset mid-window discards the partial window and any pending report.

Optional Feature:
- Macro: SEQ_MATCH_MONITOR_GAP_EN.
- When defined, adds output `rpt_min_gap` (width $clog2(WINDOW)+1).
  - Value is the minimum number of enabled cycles between consecutive matches inside the reported window.
  - The gap measurement restarts at each window start, so gaps are never measured across window boundaries.
  - All-ones if the window had fewer than 2 matches.
  - Loaded and held alongside `rpt_data` under the same handshake/overwrite rules; reset value all-ones.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package `seq_match_monitor_pkg`: FSM state typedef (QUIET, ALERT) and the all-ones gap sentinel constant.
- One natural sub-module, `seq_match_window_timer`:
  - Holds the enable-gated window counter.
  - Outputs `wend`.
  - Parameterised by WINDOW.

Test Plan (WINDOW=8, ALERT_TH=2, CNT_W=4):
- Reset and enable=1 for 8 cycles with `z` at cycles 2 and 5 -> after `wend`, `rpt_valid`=1 with `rpt_data`=2; `alert` rises the cycle after cycle 5.
- `z` on the last cycle of a window only -> `rpt_data`=1, next window starts at 0; next window `z`=0 throughout -> `rpt_data`=0 and `alert` stays 0.
- `rpt_ready` held 0 across two windows with counts 3 then 1 -> `rpt_data`=1 and `rpt_lost`=1; then `rpt_ready`=1 -> `rpt_valid` falls next cycle and `rpt_lost` stays 1 until `clr`.
- `z` tied 1 for 3 windows with CNT_W=2 -> each report is 3 (saturation) and `alert` stays 1; then a window with 0 matches -> `alert` drops after that `wend`.
- `enable`=0 for 5 cycles mid-window with `z` toggling -> report unaffected and `wend` delayed by 5 cycles.
- Async reset asserted mid-window with a pending report -> all outputs return to 0 immediately. With GAP_EN and `z` at cycles 1, 4, 6 -> `rpt_min_gap`=2.
